cordic_vectoring_core: RTL and testbench

Iterative CORDIC vectoring-mode engine that converts a signed Cartesian pair (x, y) into a magnitude and a phase angle. It is the consumer of the arctangent ROM. Each cycle it drives one ROM address and reads the same-cycle combinational arctangent word. Angle units: 2^WORD_LENGTH LSB = 360°, so 0x2000 = 45° and 0x8000 = 180°. Magnitude is not gain-corrected; it carries the CORDIC gain K ≈ 1.6468.

---
 rtl/cordic_vectoring_core.sv | 159 +++++++++++++++
 tb/tb_cordic_vectoring_core.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring_core.sv
// Iterative CORDIC vectoring engine: converts a signed (x, y) pair into an
// uncorrected magnitude (carries the CORDIC gain) and a phase angle where
// 2^WORD_LENGTH LSB equals one full turn. One micro-rotation per clock; the
// arctangent constant for iteration i is read combinationally from an
// external ROM addressed by i.
module cordic_vectoring_core #(
    parameter int WORD_LENGTH    = 16,
    parameter int ADDRESS_LENGTH = 4,
    parameter int ITERATIONS     = 14
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic signed [WORD_LENGTH-1:0]    x_in,
    input  logic signed [WORD_LENGTH-1:0]    y_in,
    output logic                             busy,
    output logic                             done,
    output logic        [WORD_LENGTH+1:0]    magnitude,
    output logic        [WORD_LENGTH-1:0]    angle,
    output logic                             rom_read_enable,
    output logic        [ADDRESS_LENGTH-1:0] rom_address,
    input  logic        [WORD_LENGTH-1:0]    rom_data
);

    // Two guard bits: one for the exact negation of the most negative input,
    // one for the CORDIC gain (K * sqrt(2) * 2^(W-1) < 2^(W+1)).
    localparam int XW = WORD_LENGTH + 2;
    localparam logic [ADDRESS_LENGTH-1:0] LAST_I = ADDRESS_LENGTH'(ITERATIONS - 1);
    localparam logic [WORD_LENGTH-1:0]    Z_HALF = {1'b1, {(WORD_LENGTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    state_t                      state_reg, state_next;
    logic signed [XW-1:0]        x_reg, x_next;
    logic signed [XW-1:0]        y_reg, y_next;
    logic [WORD_LENGTH-1:0]      z_reg, z_next;
    logic [ADDRESS_LENGTH-1:0]   i_reg, i_next;
    logic                        zero_flag_reg, zero_flag_next;
    logic [XW-1:0]               magnitude_reg, magnitude_next;
    logic [WORD_LENGTH-1:0]      angle_reg, angle_next;

    logic signed [XW-1:0]        x_ext, y_ext;
    logic signed [XW-1:0]        x_shift, y_shift;
    logic signed [XW-1:0]        x_rot, y_rot;
    logic [WORD_LENGTH-1:0]      z_rot;

    // Operands sign-extended before any negation so -(-2^(W-1)) is exact.
    assign x_ext = {{2{x_in[WORD_LENGTH-1]}}, x_in};
    assign y_ext = {{2{y_in[WORD_LENGTH-1]}}, y_in};

    // Arithmetic shifts of the pre-update vector (truncating, no rounding).
    assign x_shift = x_reg >>> i_reg;
    assign y_shift = y_reg >>> i_reg;

    // One micro-rotation: drive y toward zero, accumulate the rotated angle.
    always_comb begin
        if (!y_reg[XW-1]) begin
            x_rot = x_reg + y_shift;
            y_rot = y_reg - x_shift;
            z_rot = z_reg + rom_data;
        end else begin
            x_rot = x_reg - y_shift;
            y_rot = y_reg + x_shift;
            z_rot = z_reg - rom_data;
        end
    end

    // Next-state and datapath update for the IDLE / ITER / DONE sequence.
    always_comb begin
        state_next     = state_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        z_next         = z_reg;
        i_next         = i_reg;
        zero_flag_next = zero_flag_reg;
        magnitude_next = magnitude_reg;
        angle_next     = angle_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = ITER;
                    i_next         = '0;
                    zero_flag_next = (x_in == '0) && (y_in == '0);
                    // Left half-plane vectors are pre-rotated by 180 degrees
                    // so the micro-rotations only need to cover +/-90 degrees.
                    if (x_in[WORD_LENGTH-1]) begin
                        x_next = -x_ext;
                        y_next = -y_ext;
                        z_next = Z_HALF;
                    end else begin
                        x_next = x_ext;
                        y_next = y_ext;
                        z_next = '0;
                    end
                end
            end
            ITER: begin
                x_next = x_rot;
                y_next = y_rot;
                z_next = z_rot;
                if (i_reg == LAST_I) begin
                    state_next = DONE;
                    i_next     = '0;
                    // A zero vector has no defined phase; report all zeros.
                    if (zero_flag_reg) begin
                        magnitude_next = '0;
                        angle_next     = '0;
                    end else begin
                        magnitude_next = $unsigned(x_rot);
                        angle_next     = z_rot;
                    end
                end else begin
                    i_next = i_reg + ADDRESS_LENGTH'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            x_reg         <= '0;
            y_reg         <= '0;
            z_reg         <= '0;
            i_reg         <= '0;
            zero_flag_reg <= 1'b0;
            magnitude_reg <= '0;
            angle_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            z_reg         <= z_next;
            i_reg         <= i_next;
            zero_flag_reg <= zero_flag_next;
            magnitude_reg <= magnitude_next;
            angle_reg     <= angle_next;
        end
    end

    assign busy            = (state_reg != IDLE);
    assign done            = (state_reg == DONE);
    assign rom_read_enable = (state_reg == ITER);
    assign rom_address     = (state_reg == ITER) ? i_reg : '0;
    assign magnitude       = magnitude_reg;
    assign angle           = angle_reg;

endmodule

// File: tb/tb_cordic_vectoring_core.sv
// Testbench for cordic_vectoring_core: an ideal atan2 / K*|v| reference
// model feeds a scoreboard queue; a negedge monitor pops and compares on
// every done pulse and also watches the ROM address sequence.
module tb_cordic_vectoring_core;

    localparam int WL   = 16;
    localparam int AL   = 4;
    localparam int ITER = 14;
    localparam real PI  = 3.14159265358979323846;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic signed [WL-1:0] x_in = '0;
    logic signed [WL-1:0] y_in = '0;
    logic                 busy;
    logic                 done;
    logic [WL+1:0]        magnitude;
    logic [WL-1:0]        angle;
    logic                 rom_read_enable;
    logic [AL-1:0]        rom_address;
    logic [WL-1:0]        rom_data;

    logic [WL-1:0] rom_table [2**AL];
    real           k_gain;

    typedef struct {
        int     x;
        int     y;
        real    mag;
        real    ang;
        bit     zero;
        longint issue;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     done_count = 0;
    longint cyc = 0;
    bit     rst_seen = 1'b1;
    bit     armed = 1'b0;

    cordic_vectoring_core #(
        .WORD_LENGTH   (WL),
        .ADDRESS_LENGTH(AL),
        .ITERATIONS    (ITER)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .x_in           (x_in),
        .y_in           (y_in),
        .busy           (busy),
        .done           (done),
        .magnitude      (magnitude),
        .angle          (angle),
        .rom_read_enable(rom_read_enable),
        .rom_address    (rom_address),
        .rom_data       (rom_data)
    );

    always #5 clk = ~clk;

    // Combinational arctangent ROM: round(atan(2^-i) * 2^WL / 2pi).
    assign rom_data = rom_table[rom_address];

    initial begin
        k_gain = 1.0;
        for (int i = 0; i < 2**AL; i++) begin
            real t;
            t = 1.0 / (2.0 ** i);
            rom_table[i] = WL'($rtoi($atan(t) * 65536.0 / (2.0 * PI) + 0.5));
            if (i < ITER) k_gain = k_gain * $sqrt(1.0 + t * t);
        end
    end

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Ideal result: gain-scaled Euclidean length and atan2 in turn units.
    function automatic exp_t model(input int x, input int y);
        exp_t e;
        e.x    = x;
        e.y    = y;
        e.zero = (x == 0) && (y == 0);
        e.mag  = e.zero ? 0.0 : k_gain * $sqrt(real'(x) * x + real'(y) * y);
        e.ang  = e.zero ? 0.0 : $atan2(real'(y), real'(x)) * 65536.0 / (2.0 * PI);
        if (e.ang < 0.0) e.ang = e.ang + 65536.0;
        e.issue = 0;
        return e;
    endfunction

    // Monitor: scoreboard compare on done, ROM sequence, held results.
    longint held_mag = 0;
    longint held_ang = 0;
    int     rom_run = 0;
    always @(negedge clk) begin
        if (rst_seen) begin
            rom_run  = 0;
            held_mag = 0;
            held_ang = 0;
        end
        if (armed) begin
            if (rom_read_enable) begin
                check(rom_address == AL'(rom_run), "rom_address", rom_address, rom_run);
                rom_run++;
            end else begin
                if (rom_run != 0) check(rom_run == ITER, "rom_enable_cycles", rom_run, ITER);
                rom_run = 0;
                check(rom_address == '0, "rom_address_idle", rom_address, 0);
            end
            if (done) begin
                done_count++;
                check(busy == 1'b1, "busy_during_done", busy, 1);
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    real  d;
                    int   atol;
                    int   mtol;
                    e = sb.pop_front();
                    check(cyc == e.issue + ITER, "done_latency", cyc - e.issue, ITER);
                    if (e.zero) begin
                        check(magnitude == '0, "zero_magnitude", magnitude, 0);
                        check(angle == '0, "zero_angle", angle, 0);
                    end else begin
                        // No guard bits below the LSB: truncation loses up to
                        // one LSB per stage, and the phase resolution of the
                        // rotated vector shrinks as its length shrinks.
                        atol = 4 + $rtoi(32768.0 / e.mag);
                        mtol = 12;
                        d = real'(angle) - e.ang;
                        if (d > 32768.0) d = d - 65536.0;
                        if (d < -32768.0) d = d + 65536.0;
                        check((d <= atol) && (d >= -atol), $sformatf("angle(x=%0d,y=%0d)", e.x, e.y),
                              angle, $rtoi(e.ang + 0.5));
                        d = real'(magnitude) - e.mag;
                        check((d <= mtol) && (d >= -mtol), $sformatf("magnitude(x=%0d,y=%0d)", e.x, e.y),
                              magnitude, $rtoi(e.mag + 0.5));
                    end
                end
                held_mag = magnitude;
                held_ang = angle;
            end else begin
                check(magnitude == held_mag, "magnitude_held", magnitude, held_mag);
                check(angle == held_ang, "angle_held", angle, held_ang);
            end
        end
    end

    // Drive one start pulse; optionally record the expected result.
    task automatic issue(input int x, input int y, input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        x_in  = WL'(x);
        y_in  = WL'(y);
        if (push) begin
            e       = model(x, y);
            e.issue = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        // Operands outside the load cycle must not matter.
        x_in  = WL'($urandom);
        y_in  = WL'($urandom);
    endtask

    task automatic wait_done();
        int prev;
        prev = done_count;
        for (int k = 0; k < ITER + 8; k++) begin
            @(posedge clk);
            #1;
            if (done_count != prev) break;
        end
        check(done_count != prev, "done_timeout", done_count - prev, 1);
        if (done_count == prev) sb.delete();
    endtask

    task automatic convert(input int x, input int y);
        issue(x, y, 1'b1);
        wait_done();
        $display("conv x=%0d y=%0d -> magnitude=%0d angle=0x%04h", x, y, magnitude, angle);
    endtask

    int dir_x [10] = '{1000, 0, -1000, 1000, -32768, 0, 0, -32768, 32767, -1};
    int dir_y [10] = '{0, 1000, 0, -1000, -32768, 0, -1000, 0, 32767, -32768};

    initial begin
        int cnt0;
        int rx;
        int ry;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check(busy == 1'b0, "reset_busy", busy, 0);
        check(done == 1'b0, "reset_done", done, 0);
        check(magnitude == '0, "reset_magnitude", magnitude, 0);
        check(angle == '0, "reset_angle", angle, 0);
        check(rom_read_enable == 1'b0, "reset_rom_en", rom_read_enable, 0);
        check(rom_address == '0, "reset_rom_addr", rom_address, 0);
        armed = 1'b1;

        // Directed vectors: axes, diagonals, extremes, zero.
        for (int n = 0; n < 10; n++) convert(dir_x[n], dir_y[n]);

        // A second start while busy is ignored and not queued.
        cnt0 = done_count;
        issue(1200, 700, 1'b1);
        repeat (3) @(negedge clk);
        issue(-5000, 3000, 1'b0);
        wait_done();
        repeat (ITER + 6) @(negedge clk);
        check(done_count == cnt0 + 1, "single_done_on_restart", done_count - cnt0, 1);
        $display("restart-ignored: magnitude=%0d angle=0x%04h", magnitude, angle);

        // Reset mid-iteration discards the conversion.
        cnt0 = done_count;
        issue(3000, 4000, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check(busy == 1'b0, "midrst_busy", busy, 0);
        check(done == 1'b0, "midrst_done", done, 0);
        check(magnitude == '0, "midrst_magnitude", magnitude, 0);
        check(angle == '0, "midrst_angle", angle, 0);
        check(rom_read_enable == 1'b0, "midrst_rom_en", rom_read_enable, 0);
        check(rom_address == '0, "midrst_rom_addr", rom_address, 0);
        repeat (ITER + 5) @(negedge clk);
        check(done_count == cnt0, "no_done_after_reset", done_count - cnt0, 0);
        convert(3000, 4000);

        // Randomized back-to-back conversions with vectors long enough that
        // the fixed-point phase resolution stays fine.
        for (int n = 0; n < 24; n++) begin
            do begin
                rx = int'($urandom_range(65535)) - 32768;
                ry = int'($urandom_range(65535)) - 32768;
            end while ((longint'(rx) * rx + longint'(ry) * ry) < 64'd64000000);
            convert(rx, ry);
        end

        repeat (4) @(negedge clk);
        check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
